// File: rtl/uart_tx_serializer_if.sv
// TX FIFO read port shared between the UART TX FIFO and the transmit serializer.
// master = serializer side (pops), slave = FIFO side (supplies data/empty).
interface uart_tx_serializer_if;
   logic       fifo_empty;
   logic [7:0] fifo_data;
   logic       fifo_rd_en;

   modport master (output fifo_rd_en, input fifo_empty, input fifo_data);
   modport slave  (input fifo_rd_en, output fifo_empty, output fifo_data);
endinterface

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: pops bytes from the TX FIFO and shifts out start/data/[parity]/stop.
// Optional parity bit compiled in with `define UART_TX_PARITY_EN.
module uart_tx_serializer #(
   parameter int DIV_W = 16
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  tx_en,
   input  logic [DIV_W-1:0]      baud_div,
   input  logic                  stop2,
   input  logic                  pen,
   input  logic                  eps,
   uart_tx_serializer_if.master  fifo,
   output logic                  txd,
   output logic                  tx_busy,
   output logic                  tx_done
);

`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {IDLE, FETCH, LOAD, START, DATA, PARITY, STOP} state_t;
`else
   typedef enum logic [2:0] {IDLE, FETCH, LOAD, START, DATA, STOP} state_t;
`endif

   state_t            state;
   logic [DIV_W-1:0]  cnt;
   logic [2:0]        bit_cnt;
   logic              stop_hi;
   logic [7:0]        shift;
   logic [DIV_W-1:0]  div_q;
   logic              stop2_q;
   logic              bit_end;

   assign bit_end = (cnt == '0);

`ifdef UART_TX_PARITY_EN
   logic pen_q;
   logic par_q;
`else
   logic unused_cfg;
   assign unused_cfg = pen ^ eps;
`endif

   // Frame datapath: byte and frame config are captured once in LOAD and held for the frame.
   always_ff @(posedge clk) begin
      if (state == LOAD) begin
         shift   <= fifo.fifo_data;
         div_q   <= baud_div;
         stop2_q <= stop2;
`ifdef UART_TX_PARITY_EN
         pen_q   <= pen;
         par_q   <= eps ? ^fifo.fifo_data : ~^fifo.fifo_data;
`endif
      end else if (state == DATA && bit_end) begin
         shift <= {1'b0, shift[7:1]};
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state           <= IDLE;
         cnt             <= '0;
         bit_cnt         <= '0;
         stop_hi         <= 1'b0;
         txd             <= 1'b1;
         fifo.fifo_rd_en <= 1'b0;
         tx_busy         <= 1'b0;
         tx_done         <= 1'b0;
      end else begin
         fifo.fifo_rd_en <= 1'b0;
         tx_done         <= 1'b0;
         case (state)
            IDLE: begin
               txd     <= 1'b1;
               tx_busy <= 1'b0;
               if (tx_en && !fifo.fifo_empty) begin
                  state           <= FETCH;
                  fifo.fifo_rd_en <= 1'b1;
                  tx_busy         <= 1'b1;
               end
            end
            FETCH: state <= LOAD;
            LOAD: begin
               state   <= START;
               bit_cnt <= '0;
               stop_hi <= 1'b0;
               cnt     <= baud_div;
               txd     <= 1'b0;
            end
            START: begin
               if (bit_end) begin
                  state <= DATA;
                  cnt   <= div_q;
                  txd   <= shift[0];
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            DATA: begin
               if (bit_end) begin
                  cnt <= div_q;
                  if (bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                     if (pen_q) begin
                        state <= PARITY;
                        txd   <= par_q;
                     end else begin
                        state <= STOP;
                        txd   <= 1'b1;
                     end
`else
                     state <= STOP;
                     txd   <= 1'b1;
`endif
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                     txd     <= shift[1];
                  end
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
               if (bit_end) begin
                  state <= STOP;
                  cnt   <= div_q;
                  txd   <= 1'b1;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
`endif
            STOP: begin
               if (bit_end) begin
                  if (stop2_q && !stop_hi) begin
                     stop_hi <= 1'b1;
                     cnt     <= div_q;
                  end else begin
                     // tx_done lands in the following FETCH/IDLE cycle, never during a start bit
                     stop_hi <= 1'b0;
                     tx_done <= 1'b1;
                     if (tx_en && !fifo.fifo_empty) begin
                        state           <= FETCH;
                        fifo.fifo_rd_en <= 1'b1;
                     end else begin
                        state   <= IDLE;
                        tx_busy <= 1'b0;
                     end
                  end
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer: registered FIFO model, per-cycle capture of outputs,
// frame checks against hand-built bit sequences.
module tb_uart_tx_serializer;
   localparam int HMAX = 256;

   logic        clk;
   logic        rstn;
   logic        tx_en;
   logic [15:0] baud_div;
   logic        stop2;
   logic        pen;
   logic        eps;
   logic        txd;
   logic        tx_busy;
   logic        tx_done;

   uart_tx_serializer_if ifc ();

   uart_tx_serializer #(.DIV_W(16)) dut (
      .clk      (clk),
      .rstn     (rstn),
      .tx_en    (tx_en),
      .baud_div (baud_div),
      .stop2    (stop2),
      .pen      (pen),
      .eps      (eps),
      .fifo     (ifc),
      .txd      (txd),
      .tx_busy  (tx_busy),
      .tx_done  (tx_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Registered-read FIFO model: data appears the cycle after the pop strobe.
   logic [7:0] fmem [16];
   int         wptr = 0;
   int         rptr = 0;
   assign ifc.fifo_empty = (wptr == rptr);
   always @(posedge clk) begin
      if (ifc.fifo_rd_en && (wptr != rptr)) begin
         ifc.fifo_data <= fmem[rptr[3:0]];
         rptr          <= rptr + 1;
      end
   end

   int   n_cmp  = 0;
   int   n_fail = 0;
   logic txd_h  [HMAX];
   logic rd_h   [HMAX];
   logic done_h [HMAX];
   logic busy_h [HMAX];
   int   hn    = 0;
   int   pops  = 0;
   int   dones = 0;
   int   viol  = 0;

   task automatic chk(input string tag, input int obs, input int exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [7:0] b);
      fmem[wptr[3:0]] = b;
      wptr = wptr + 1;
   endtask

   task automatic clr();
      hn    = 0;
      pops  = 0;
      dones = 0;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         if (hn < HMAX) begin
            txd_h[hn]  = txd;
            rd_h[hn]   = ifc.fifo_rd_en;
            done_h[hn] = tx_done;
            busy_h[hn] = tx_busy;
            hn++;
         end
         if (ifc.fifo_rd_en) pops++;
         if (tx_done) dones++;
         if (ifc.fifo_rd_en && ifc.fifo_empty) viol++;
      end
   endtask

   function automatic int count_low(input int from, input int to);
      int c = 0;
      for (int i = from; i < to; i++) if (txd_h[i] !== 1'b1) c++;
      return c;
   endfunction

   function automatic int count_busy(input int from, input int to);
      int c = 0;
      for (int i = from; i < to; i++) if (busy_h[i] !== 1'b0) c++;
      return c;
   endfunction

   // Checks every cycle of a frame starting at history index st, plus the idle-high cycle on each side.
   task automatic chk_frame(input string tag, input int st, input logic [7:0] b, input int per,
                            input logic has_par, input logic par, input int nstop);
      logic [11:0] bits;
      int          nb;
      bits    = '1;
      bits[0] = 1'b0;
      for (int i = 0; i < 8; i++) bits[1+i] = b[i];
      nb = 9;
      if (has_par) begin
         bits[nb] = par;
         nb++;
      end
      nb += nstop;
      for (int i = 0; i < nb; i++)
         for (int c = 0; c < per; c++)
            chk($sformatf("%s bit%0d cyc%0d", tag, i, c), 32'(txd_h[st + i*per + c]), 32'(bits[i]));
      chk({tag, " pre-idle"},  32'(txd_h[st-1]),         1);
      chk({tag, " post-idle"}, 32'(txd_h[st + nb*per]), 1);
   endtask

   int fz;
   int nbits;

   initial begin
      rstn     = 1'b1;
      tx_en    = 1'b0;
      baud_div = 16'd3;
      stop2    = 1'b0;
      pen      = 1'b0;
      eps      = 1'b0;
      #1 rstn  = 1'b0;

      // Reset state, then 100 cycles with data waiting but tx_en low
      push(8'h55);
      repeat (3) @(posedge clk);
      #1;
      chk("rst txd",     32'(txd),            1);
      chk("rst rd_en",   32'(ifc.fifo_rd_en), 0);
      chk("rst busy",    32'(tx_busy),        0);
      chk("rst done",    32'(tx_done),        0);
      rstn = 1'b1;
      clr();
      run(100);
      chk("idle pops",   pops,                 0);
      chk("idle lows",   count_low(0, 100),    0);
      chk("idle busy",   count_busy(0, 100),   0);
      chk("idle done",   dones,                0);

      // 0x55, 4-cycle bits, one stop bit
      tx_en = 1'b1;
      clr();
      run(50);
      fz = -1;
      for (int i = 49; i >= 0; i--) if (txd_h[i] === 1'b0) fz = i;
      chk("x55 latency",   fz,               2);
      chk("x55 rd_en",     32'(rd_h[0]),     1);
      chk("x55 busy fetch",32'(busy_h[0]),   1);
      chk_frame("x55", 2, 8'h55, 4, 1'b0, 1'b0, 1);
      chk("x55 busy last", 32'(busy_h[41]),  1);
      chk("x55 busy idle", 32'(busy_h[42]),  0);
      chk("x55 done pos",  32'(done_h[42]),  1);
      chk("x55 dones",     dones,            1);
      chk("x55 pops",      pops,             1);

      // 0xA3, 1-cycle bits, two stop bits, parity requested (even, then odd)
      baud_div = 16'd0;
      stop2    = 1'b1;
      pen      = 1'b1;
`ifdef UART_TX_PARITY_EN
      nbits = 12;
`else
      nbits = 11;
`endif
      eps = 1'b1;
      push(8'hA3);
      clr();
      run(20);
`ifdef UART_TX_PARITY_EN
      chk_frame("xA3 even", 2, 8'hA3, 1, 1'b1, 1'b0, 2);
`else
      chk_frame("xA3 nopar", 2, 8'hA3, 1, 1'b0, 1'b0, 2);
`endif
      chk("xA3 even done", 32'(done_h[2 + nbits]), 1);
      chk("xA3 even dones", dones, 1);
      eps = 1'b0;
      push(8'hA3);
      clr();
      run(20);
`ifdef UART_TX_PARITY_EN
      chk_frame("xA3 odd", 2, 8'hA3, 1, 1'b1, 1'b1, 2);
`else
      chk_frame("xA3 nopar2", 2, 8'hA3, 1, 1'b0, 1'b0, 2);
`endif
      chk("xA3 odd done", 32'(done_h[2 + nbits]), 1);
      chk("xA3 odd pops", pops, 1);

      // Three back-to-back bytes, 2-cycle bits
      baud_div = 16'd1;
      stop2    = 1'b0;
      pen      = 1'b0;
      push(8'h01);
      push(8'h80);
      push(8'hFF);
      clr();
      run(80);
      chk_frame("b2b 01", 2,  8'h01, 2, 1'b0, 1'b0, 1);
      chk_frame("b2b 80", 24, 8'h80, 2, 1'b0, 1'b0, 1);
      chk_frame("b2b FF", 46, 8'hFF, 2, 1'b0, 1'b0, 1);
      chk("b2b gap0",     32'(txd_h[22]),  1);
      chk("b2b gap1",     32'(txd_h[23]),  1);
      chk("b2b pop2",     32'(rd_h[22]),   1);
      chk("b2b pop3",     32'(rd_h[44]),   1);
      chk("b2b done1",    32'(done_h[22]), 1);
      chk("b2b done2",    32'(done_h[44]), 1);
      chk("b2b done3",    32'(done_h[66]), 1);
      chk("b2b dones",    dones,           3);
      chk("b2b pops",     pops,            3);
      chk("b2b idle",     32'(busy_h[66]), 0);
      chk("b2b idle end", count_busy(66, 80), 0);

      // Divisor change and tx_en drop mid-frame; next frame picks up the new divisor
      baud_div = 16'd3;
      push(8'h3C);
      push(8'hC5);
      clr();
      run(10);
      baud_div = 16'd7;
      tx_en    = 1'b0;
      run(50);
      chk_frame("chg 3C", 2, 8'h3C, 4, 1'b0, 1'b0, 1);
      chk("chg done",   32'(done_h[42]),   1);
      chk("chg pops",   pops,              1);
      chk("chg idle",   count_busy(42, 60), 0);
      chk("chg quiet",  count_low(42, 60),  0);
      tx_en = 1'b1;
      run(100);
      chk_frame("chg C5", 62, 8'hC5, 8, 1'b0, 1'b0, 1);
      chk("chg pops2",  pops,              2);
      chk("chg done2",  32'(done_h[142]),  1);

      // Asynchronous reset during data bit 4
      baud_div = 16'd3;
      push(8'h0F);
      clr();
      run(23);
      chk("rst bit4 low", 32'(txd_h[22]), 0);
      rstn = 1'b0;
      #1;
      chk("rst async txd",  32'(txd),            1);
      chk("rst async busy", 32'(tx_busy),        0);
      chk("rst async rd",   32'(ifc.fifo_rd_en), 0);
      @(posedge clk);
      #1;
      rstn = 1'b1;
      clr();
      run(20);
      chk("post rst pops",  pops,               0);
      chk("post rst lows",  count_low(0, 20),   0);
      chk("post rst busy",  count_busy(0, 20),  0);
      push(8'h5A);
      clr();
      run(50);
      chk_frame("post rst 5A", 2, 8'h5A, 4, 1'b0, 1'b0, 1);
      chk("post rst pops2", pops,              1);
      chk("post rst done",  32'(done_h[42]),   1);

      chk("rd_en while empty", viol, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule

// File: doc/uart_tx_serializer.md
# uart_tx_serializer

Transmit-side serializer for the APB UART. It drains 8-bit bytes from the TX FIFO through the FIFO's read port and shifts each one onto the serial line as an asynchronous frame. A frame is a start bit, 8 data bits LSB first, optional parity, and 1 or 2 stop bits. It is the counterpart of the receive path feeding the RX FIFO, and shares the 16-deep, 8-bit FIFO block with it.

## Interface
Parameters:
- DIV_W, 16, width of the baud divisor input.

Ports:
- clk  input  1  ARM functional clock; all logic is on the rising edge.
- rstn  input  1  ARM reset, asynchronous, active-low.
- tx_en  input  1  Transmit enable. Sampled only when a new frame may start.
- baud_div  input  DIV_W  Bit period minus one, in clk cycles (bit period = baud_div+1).
- stop2  input  1  1 = two stop bits, 0 = one stop bit.
- pen  input  1  Parity enable. Used only when UART_TX_PARITY_EN is defined.
- eps  input  1  Even parity select (1 even, 0 odd). Used only when UART_TX_PARITY_EN is defined.
- fifo_empty  input  1  TX FIFO read-empty flag.
- fifo_data  input  8  TX FIFO read data. Registered; valid the cycle after fifo_rd_en.
- fifo_rd_en  output  1  One-cycle FIFO pop strobe.
- txd  output  1  Serial output. Idle high.
- tx_busy  output  1  High from the pop cycle through the last stop-bit cycle.
- tx_done  output  1  One-cycle pulse in the cycle after the final stop bit ends.

## Operation
- FSM states: IDLE, FETCH, LOAD, START, DATA, PARITY, STOP.
- IDLE:
  - txd=1.
  - If tx_en=1 and fifo_empty=0, go to FETCH.
- FETCH: fifo_rd_en=1 for exactly this cycle; go to LOAD.
- LOAD:
  - Capture fifo_data into the shift register.
  - Latch baud_div, stop2, pen and eps into frame-config registers.
  - Clear the bit counter; go to START.
- START: txd=0 for one bit period; go to DATA.
- DATA:
  - txd = shift[0]; shift right at the end of each bit period.
  - After 8 bits, go to PARITY if the latched pen=1 (macro defined); otherwise go to STOP.
- PARITY:
  - txd = ^data if eps=1 (even); txd = ~^data if eps=0 (odd).
  - One bit period; go to STOP.
- STOP:
  - txd=1 for 1 or 2 bit periods, per the latched stop2.
  - At the end: pulse tx_done. Go to FETCH if tx_en=1 and fifo_empty=0; otherwise go to IDLE.
- Bit timer:
  - A DIV_W-bit down-counter is loaded with the latched divisor at the start of each bit.
  - A bit ends in the cycle the counter reads 0.
  - baud_div=0 gives one clk per bit.
- Changes to baud_div, stop2, pen or eps mid-frame do not affect the current frame.
- tx_en deasserted mid-frame: the current frame completes; no further pop.
- fifo_rd_en is never asserted while fifo_empty=1.
- At most one pop is issued per frame.

## Timing
- Reset values: txd=1, fifo_rd_en=0, tx_busy=0, tx_done=0, FSM=IDLE, counters 0.
- rstn low mid-frame forces txd=1 asynchronously and abandons the byte. The byte already popped is lost.
- Latency from an IDLE cycle with tx_en=1 and fifo_empty=0 to the falling edge of txd is 3 cycles (FETCH, LOAD, then START begins).
- Frame length is (1+8+P+S)·(baud_div+1) cycles, where P ∈ {0,1} and S ∈ {1,2}.
- Back-to-back frames: txd stays high for 2 extra cycles (FETCH, LOAD) between the end of stop and the next start bit.
- tx_done is asserted in the FETCH or IDLE cycle that follows STOP. It does not overlap txd=0.
- tx_busy=1 in FETCH through STOP inclusive; 0 in IDLE.

## Configuration
- UART_TX_PARITY_EN:
  - Defined: the PARITY state and parity logic are compiled in, and pen/eps act as described above.
  - Undefined: the PARITY state is absent and pen/eps are ignored (ports remain). Frames never carry a parity bit.

## Test plan
- Reset with tx_en=0 -> txd=1, fifo_rd_en=0, tx_busy=0, tx_done=0; no pop for 100 cycles even with fifo_empty=0.
- FIFO holds 0x55; baud_div=3, stop2=0, pen=0, tx_en=1 -> one pop; txd sequence per 4-cycle bit: 0,1,0,1,0,1,0,1,0,1; total frame 40 cycles; tx_done pulses once.
- Macro defined; 0xA3 with pen=1, eps=1, stop2=1, baud_div=0 -> txd: 0,1,1,0,0,0,1,0,1,(parity=0),1,1; with eps=0 the parity bit is 1.
- FIFO holds 3 bytes (0x01, 0x80, 0xFF), baud_div=1 -> exactly 3 pops; 2-cycle high gap between frames; IDLE after the third tx_done; fifo_rd_en never high with fifo_empty=1.
- Change baud_div 3→7 and deassert tx_en during DATA -> the current frame keeps 4-cycle bits and completes; no further pop; the next frame (after tx_en=1) uses 8-cycle bits.
- rstn pulsed low during bit 4 of a frame -> txd=1 in the same cycle; after release FSM=IDLE; the next frame starts only on a fresh pop.
